alu_cmd_queue: RTL and testbench

Command buffer directly upstream of the registered 4-bit ALU stage. It captures operand pairs and opcodes from the pins on a synchronized write strobe and holds them in a DEPTH-entry FIFO. It then issues them to the ALU one at a time over a valid/ready handshake. This decouples slow manual or host pin writes from the ALU's per-cycle evaluation and reports fill level and overflow.

---
 rtl/alu_cmd_queue.sv | 104 ++++++++++
 tb/tb_alu_cmd_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - strobe-fed command FIFO issuing {a, b, op} to the ALU stage over valid/ready
module alu_cmd_queue #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               wr_data,
    input  logic [2:0]               wr_op,
    input  logic                     wr_strobe,
    input  logic                     clear,
    output logic [3:0]               cmd_a,
    output logic [3:0]               cmd_b,
    output logic [2:0]               cmd_op,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   push_req;
    logic                   pop;
    logic                   push_ok;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [CW-1:0]          count;
    logic [10:0]            mem [DEPTH];
    logic [10:0]            head;

    // The chain resets to 0, so a strobe already high at release still yields one push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], wr_strobe};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign push_req = sync_q[SYNC_STAGES-1] & ~sync_prev;
    assign pop      = cmd_valid & cmd_ready;
    // A pop on a full queue frees the slot the simultaneous push lands in.
    assign push_ok  = push_req & (~fifo_full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear && push_ok) begin
            mem[wr_ptr] <= {wr_data, wr_op};
        end
    end

    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign cmd_valid  = ~fifo_empty;

    // Storage is never reset, so the head is masked while empty.
    always_comb begin
        cmd_a  = 4'd0;
        cmd_b  = 4'd0;
        cmd_op = 3'd0;
        if (!fifo_empty) begin
            cmd_a  = head[10:7];
            cmd_b  = head[6:3];
            cmd_op = head[2:0];
        end
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb/tb_alu_cmd_queue.sv - directed bench with queue-based reference model for alu_cmd_queue
module tb_alu_cmd_queue;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [2:0] wr_op = 3'd0;
    logic       wr_strobe = 1'b0;
    logic       clear = 1'b0;
    logic       cmd_ready = 1'b0;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic       cmd_valid;
    logic [2:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    alu_cmd_queue #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_op(wr_op),
        .wr_strobe(wr_strobe), .clear(clear), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_op(cmd_op), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of entries, list of edge numbers at which pushes land.
    logic [10:0] mq[$];
    int          pend[$];
    int          ecnt = 0;
    bit          prev_s = 0;
    bit          movf = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit do_push;
        if (!rst_n) begin
            mq.delete();
            pend.delete();
            prev_s = 0;
            movf   = 0;
            ecnt   = 0;
        end else begin
            ecnt++;
            do_push = 0;
            if (pend.size() > 0 && pend[0] == ecnt) begin
                do_push = 1;
                void'(pend.pop_front());
            end
            if (wr_strobe && !prev_s) pend.push_back(ecnt + SYNC);
            prev_s = wr_strobe;
            if (clear) begin
                mq.delete();
                movf = 0;
            end else begin
                if (mq.size() > 0 && cmd_ready) void'(mq.pop_front());
                if (do_push) begin
                    if (mq.size() < DEPTH) mq.push_back({wr_data, wr_op});
                    else movf = 1;
                end
            end
        end
    end

    logic [7:0] issued[$];

    always @(negedge clk) begin : compare
        int n;
        n = mq.size();
        chk("cmd_valid", int'(cmd_valid), int'(n != 0));
        chk("fifo_count", int'(fifo_count), n);
        chk("fifo_full", int'(fifo_full), int'(n == DEPTH));
        chk("fifo_empty", int'(fifo_empty), int'(n == 0));
        chk("overflow", int'(overflow), int'(movf));
        chk("cmd_a", int'(cmd_a), (n != 0) ? int'(mq[0][10:7]) : 0);
        chk("cmd_b", int'(cmd_b), (n != 0) ? int'(mq[0][6:3]) : 0);
        chk("cmd_op", int'(cmd_op), (n != 0) ? int'(mq[0][2:0]) : 0);
        if (rst_n && !clear && cmd_valid && cmd_ready) issued.push_back({cmd_a, cmd_b});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobe sampled at E1, push lands at E3; data held until the next call.
    task automatic push(input logic [7:0] d, input logic [2:0] op, input bit align);
        tick(1);
        wr_data = d;
        wr_op = op;
        wr_strobe = 1'b1;
        tick(1);
        wr_strobe = 1'b0;
        tick(1);
        if (align) cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
    endtask

    task automatic do_clear();
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic drain();
        cmd_ready = 1'b1;
        tick(6);
        cmd_ready = 1'b0;
    endtask

    logic [7:0] pushed[$];

    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stim
        logic [7:0] d;
        tick(2);
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_empty", int'(fifo_empty), 1);
        rst_n = 1'b1;
        tick(1);

        // Single pulse: visible two edges after the sampled strobe edge.
        wr_data = 8'h53;
        wr_op = 3'd0;
        wr_strobe = 1'b1;
        tick(1);
        wr_strobe = 1'b0;
        tick(1);
        chk("t1_not_yet", int'(cmd_valid), 0);
        tick(1);
        chk("t1_valid", int'(cmd_valid), 1);
        chk("t1_a", int'(cmd_a), 5);
        chk("t1_b", int'(cmd_b), 3);
        chk("t1_op", int'(cmd_op), 0);
        chk("t1_count", int'(fifo_count), 1);

        // Long strobe gives exactly one push.
        do_clear();
        wr_data = 8'h7e;
        wr_op = 3'd6;
        wr_strobe = 1'b1;
        tick(10);
        wr_strobe = 1'b0;
        tick(4);
        chk("hold_count", int'(fifo_count), 1);
        chk("hold_op", int'(cmd_op), 6);

        // Overflow: fifth push is dropped, first four issue back to back.
        do_clear();
        for (int i = 1; i <= 5; i++) push(8'(i * 8'h11), 3'(i), 1'b0);
        tick(2);
        chk("ovf_count", int'(fifo_count), 4);
        chk("ovf_full", int'(fifo_full), 1);
        chk("ovf_flag", int'(overflow), 1);
        chk("model_ovf_count", mq.size(), 4);
        issued.delete();
        cmd_ready = 1'b1;
        tick(4);
        chk("ovf_drained", int'(fifo_count), 0);
        tick(2);
        cmd_ready = 1'b0;
        chk("ovf_issued_n", issued.size(), 4);
        for (int i = 0; i < 4 && i < issued.size(); i++)
            chk("ovf_issued", int'(issued[i]), (i + 1) * 8'h11);
        chk("ovf_sticky", int'(overflow), 1);

        // Full queue with aligned pop: push accepted, pointers wrap repeatedly.
        do_clear();
        issued.delete();
        pushed.delete();
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'hA1 + i);
            pushed.push_back(d);
            push(d, 3'(i), 1'b0);
        end
        chk("wrap_full", int'(fifo_full), 1);
        for (int i = 0; i < 18; i++) begin
            d = 8'(8'h60 + i * 9);
            pushed.push_back(d);
            push(d, 3'(i % 8), 1'b1);
            chk("wrap_count", int'(fifo_count), 4);
            chk("wrap_ovf", int'(overflow), 0);
        end
        drain();
        chk("wrap_issued_n", issued.size(), pushed.size());
        for (int i = 0; i < issued.size() && i < pushed.size(); i++)
            chk("wrap_order", int'(issued[i]), int'(pushed[i]));
        chk("wrap_first", int'(issued[0]), 8'hA1);
        chk("wrap_fifth", int'(issued[4]), 8'h60);

        // Clear on the push edge with two entries queued.
        do_clear();
        push(8'h12, 3'd1, 1'b0);
        push(8'h34, 3'd2, 1'b0);
        chk("clr_pre", int'(fifo_count), 2);
        tick(1);
        wr_data = 8'h56;
        wr_op = 3'd3;
        wr_strobe = 1'b1;
        tick(1);
        wr_strobe = 1'b0;
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_count", int'(fifo_count), 0);
        chk("clr_empty", int'(fifo_empty), 1);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_a", int'(cmd_a), 0);
        chk("clr_b", int'(cmd_b), 0);
        chk("clr_op", int'(cmd_op), 0);
        tick(3);
        chk("clr_after", int'(fifo_count), 0);

        // Asynchronous reset between edges with three entries queued.
        for (int i = 0; i < 3; i++) push(8'(8'hC3 + i), 3'(i), 1'b0);
        chk("ar_pre", int'(fifo_count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", int'(cmd_valid), 0);
        chk("ar_count", int'(fifo_count), 0);
        chk("ar_empty", int'(fifo_empty), 1);
        chk("ar_a", int'(cmd_a), 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("ar_no_push", int'(fifo_count), 0);

        // Strobe held high through reset release yields one push.
        rst_n = 1'b0;
        wr_data = 8'h9d;
        wr_op = 3'd7;
        wr_strobe = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        wr_strobe = 1'b0;
        tick(3);
        chk("rel_count", int'(fifo_count), 1);
        chk("rel_a", int'(cmd_a), 9);
        chk("rel_op", int'(cmd_op), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
